// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator for the decode stage. Takes one 32-bit
//   instruction plus its PC tag per cycle, extracts the I/S/B/U/J immediate
//   (or the 5-bit CSR zimm) extended to XLEN, and tags each entry with its
//   format and an opcode-legality flag. A main register plus a one-entry skid
//   register keep in_ready a pure function of flopped state while sustaining
//   one transfer per cycle.
//
// Parameters
//   XLEN         datapath width (32 or 64); immediates are extended to XLEN
//   EN_CSR_ZIMM  1: SYSTEM with funct3[2]=1 yields a zero-extended zimm (fmt Z)
//                0: every SYSTEM instruction is treated as I-format
//
// Ports
//   clk, rst_n             clock (rising edge) / asynchronous active-low reset
//   flush                  synchronous flush, drops every held entry
//   in_valid/in_ready      input handshake (in_ready depends only on state)
//   in_instr, in_pc        raw instruction and PC tag
//   out_valid/out_ready    output handshake
//   out_imm, out_fmt       extended immediate and format code
//   out_illegal, out_pc    unrecognised opcode flag and PC tag of the entry
//
// Handshake: a word moves on any rising edge where valid && ready are both
// high. A producer holding valid may not withdraw or change its word until it
// is taken; out_* is held stable while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit EN_CSR_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    // EMPTY: nothing held; FULL: main register holds the output entry;
    // SKID: main and skid both hold entries, input is blocked.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [31:0]     raw_imm;   // immediate as a 32-bit value before XLEN extension
    logic            raw_sext;  // 1: extend raw_imm by replicating bit 31
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    assign opcode = in_instr[6:0];

    always_comb begin
        raw_imm  = 32'd0;
        raw_sext = 1'b1;
        dec_fmt  = FMT_NONE;
        dec_ill  = 1'b0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
                dec_fmt = FMT_I;
                raw_imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    raw_imm = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                raw_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                raw_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                raw_imm = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                raw_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1110011: begin
                if (EN_CSR_ZIMM && in_instr[14]) begin
                    dec_fmt  = FMT_Z;
                    raw_imm  = {27'd0, in_instr[19:15]};
                    raw_sext = 1'b0;
                end else begin
                    dec_fmt = FMT_I;
                    raw_imm = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0110011: begin
                dec_fmt = FMT_NONE;
            end
            7'b0111011: begin
                // OP-32 only exists on RV64
                dec_ill = (XLEN != 64);
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        dec_imm = raw_sext ? XLEN'($signed(raw_imm)) : XLEN'(raw_imm);
    end

    // ------------------------------------------------------------------
    // Handshake control FSM
    // ------------------------------------------------------------------
    logic accept;
    logic drain;
    logic load_main_in;    // main <= freshly decoded input
    logic load_main_skid;  // main <= skid contents
    logic load_skid;       // skid <= freshly decoded input

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    // An instruction offered in a flush cycle is discarded, never accepted.
    assign accept    = in_valid && in_ready && !flush;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        // Replace the leaving entry directly: no bubble.
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = ST_SKID;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. Data fields are only written on a load; validity is
    // carried entirely by the state register.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] m_imm, s_imm;
    logic [2:0]      m_fmt, s_fmt;
    logic            m_ill, s_ill;
    logic [XLEN-1:0] m_pc,  s_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_imm <= '0;
            m_fmt <= FMT_NONE;
            m_ill <= 1'b0;
            m_pc  <= '0;
        end else if (load_main_in) begin
            m_imm <= dec_imm;
            m_fmt <= dec_fmt;
            m_ill <= dec_ill;
            m_pc  <= in_pc;
        end else if (load_main_skid) begin
            m_imm <= s_imm;
            m_fmt <= s_fmt;
            m_ill <= s_ill;
            m_pc  <= s_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_imm <= '0;
            s_fmt <= FMT_NONE;
            s_ill <= 1'b0;
            s_pc  <= '0;
        end else if (load_skid) begin
            s_imm <= dec_imm;
            s_fmt <= dec_fmt;
            s_ill <= dec_ill;
            s_pc  <= in_pc;
        end
    end

    assign out_imm     = m_imm;
    assign out_fmt     = m_fmt;
    assign out_illegal = m_ill;
    assign out_pc      = m_pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Drives one XLEN=32 and one XLEN=64 instance from the same stimulus and
//   checks both against a queue-based behavioural model every cycle, plus
//   hand-computed literal expectations for the decode vectors, reset,
//   backpressure, ordering and flush behaviour.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32, out_pc32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64, out_pc64;
    logic [2:0]  out_fmt64;

    imm_gen_pipe #(.XLEN(32), .EN_CSR_ZIMM(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_illegal(out_ill32), .out_pc(out_pc32)
    );

    imm_gen_pipe #(.XLEN(64), .EN_CSR_ZIMM(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_ill64), .out_pc(out_pc64)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct {
        dec_t        d32;
        dec_t        d64;
        logic [63:0] pc;
    } entry_t;

    // Immediate value computed as a signed integer from the field weights.
    function automatic dec_t model_dec(input logic [31:0] instr, input bit is64);
        dec_t   r;
        longint v;
        r.imm = '0;
        r.fmt = 3'd0;
        r.ill = 1'b0;
        v     = 0;
        case (instr[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: begin
                r.fmt = 3'd1;
                v = longint'(instr[31:20]);
                if (instr[31]) v = v - 4096;
            end
            7'h1B: begin
                if (is64) begin
                    r.fmt = 3'd1;
                    v = longint'(instr[31:20]);
                    if (instr[31]) v = v - 4096;
                end else begin
                    r.ill = 1'b1;
                end
            end
            7'h23: begin
                r.fmt = 3'd2;
                v = longint'(instr[31:25]) * 32 + longint'(instr[11:7]);
                if (instr[31]) v = v - 4096;
            end
            7'h63: begin
                r.fmt = 3'd3;
                v = longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048
                  + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
                if (instr[31]) v = v - 8192;
            end
            7'h37, 7'h17: begin
                r.fmt = 3'd4;
                v = longint'(instr[31:12]) * 4096;
                if (instr[31]) v = v - 64'sh1_0000_0000;
            end
            7'h6F: begin
                r.fmt = 3'd5;
                v = longint'(instr[31]) * 1048576 + longint'(instr[19:12]) * 4096
                  + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
                if (instr[31]) v = v - 2097152;
            end
            7'h73: begin
                if (instr[14]) begin
                    r.fmt = 3'd6;
                    v = longint'(instr[19:15]);
                end else begin
                    r.fmt = 3'd1;
                    v = longint'(instr[31:20]);
                    if (instr[31]) v = v - 4096;
                end
            end
            7'h33: r.ill = 1'b0;
            7'h3B: r.ill = !is64;
            default: r.ill = 1'b1;
        endcase
        r.imm = is64 ? 64'(v) : (64'(v) & 64'h0000_0000_FFFF_FFFF);
        return r;
    endfunction

    entry_t      mq[$];      // model of the entries held by the block
    logic [63:0] log_pc[$];  // PC tags the DUT actually handed downstream
    int          mq_sz;
    entry_t      new_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            mq_sz = mq.size();
            if (out_valid32 && out_ready) log_pc.push_back({32'd0, out_pc32});
            if (flush) begin
                mq.delete();
            end else begin
                if (out_ready && mq_sz > 0) void'(mq.pop_front());
                if (in_valid && mq_sz < 2) begin
                    new_e.d32 = model_dec(in_instr, 1'b0);
                    new_e.d64 = model_dec(in_instr, 1'b1);
                    new_e.pc  = in_pc;
                    mq.push_back(new_e);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready32",  in_ready32,  mq.size() < 2);
            check("in_ready64",  in_ready64,  mq.size() < 2);
            check("out_valid32", out_valid32, mq.size() > 0);
            check("out_valid64", out_valid64, mq.size() > 0);
            if (mq.size() > 0) begin
                check("imm32", out_imm32, mq[0].d32.imm);
                check("fmt32", out_fmt32, mq[0].d32.fmt);
                check("ill32", out_ill32, mq[0].d32.ill);
                check("pc32",  out_pc32,  {32'd0, mq[0].pc[31:0]});
                check("imm64", out_imm64, mq[0].d64.imm);
                check("fmt64", out_fmt64, mq[0].d64.fmt);
                check("ill64", out_ill64, mq[0].d64.ill);
                check("pc64",  out_pc64,  mq[0].pc);
            end
        end
    end

    // ---------------- driver ----------------
    // Offers one instruction and keeps it valid until it is taken (bounded).
    task automatic push(input logic [31:0] instr, input logic [63:0] pc);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed vectors ----------------
    localparam int NV = 12;
    logic [31:0] v_instr[NV] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                                 32'h300FD073, 32'h800000B7, 32'h0010009B, 32'h00000000,
                                 32'h00000033, 32'h0000003B, 32'hFFDFF06F, 32'h30002073};
    logic [31:0] v_imm32[NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                 32'h0000001F, 32'h80000000, 32'h00000000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'hFFFFFFFC, 32'h00000300};
    logic [2:0]  v_fmt32[NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd4, 3'd0, 3'd0,
                                 3'd0, 3'd0, 3'd5, 3'd1};
    logic        v_ill32[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] v_imm64[NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                 64'hFFFFFFFFFFFFFFF8, 64'h0000000012345000,
                                 64'h000000000000001F, 64'hFFFFFFFF80000000,
                                 64'h0000000000000001, 64'h0000000000000000,
                                 64'h0000000000000000, 64'h0000000000000000,
                                 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000300};
    logic [2:0]  v_fmt64[NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd4, 3'd1, 3'd0,
                                 3'd0, 3'd0, 3'd5, 3'd1};
    logic        v_ill64[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_t m;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;

        // Reset state
        #1;
        check("rst_out_valid", out_valid32, 1'b0);
        check("rst_in_ready",  in_ready32,  1'b1);
        check("rst_out_imm",   out_imm64,   64'd0);
        check("rst_out_fmt",   out_fmt32,   3'd0);
        check("rst_out_pc",    out_pc64,    64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Decode vectors, one at a time, with literal expectations for the
        // DUT and for the model.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            m = model_dec(v_instr[i], 1'b0);
            check("model_imm32", m.imm, {32'd0, v_imm32[i]});
            check("model_fmt32", m.fmt, v_fmt32[i]);
            check("model_ill32", m.ill, v_ill32[i]);
            m = model_dec(v_instr[i], 1'b1);
            check("model_imm64", m.imm, v_imm64[i]);
            check("model_fmt64", m.fmt, v_fmt64[i]);
            check("model_ill64", m.ill, v_ill64[i]);
            push(v_instr[i], 64'h1000 + 64'(i * 4));
            check("vec_valid", out_valid32, 1'b1);
            check("vec_imm32", out_imm32, v_imm32[i]);
            check("vec_fmt32", out_fmt32, v_fmt32[i]);
            check("vec_ill32", out_ill32, v_ill32[i]);
            check("vec_imm64", out_imm64, v_imm64[i]);
            check("vec_fmt64", out_fmt64, v_fmt64[i]);
            check("vec_ill64", out_ill64, v_ill64[i]);
        end

        // Back-to-back stream with no backpressure
        for (int i = 0; i < NV; i++) push(v_instr[NV-1-i], 64'h2000 + 64'(i * 4));
        idle(3);

        // Backpressure: only two entries fit while the output is stalled
        out_ready = 1'b0;
        log_pc.delete();
        push(32'hFFF00093, 64'h100);
        push(32'hFE112E23, 64'h104);
        check("bp_in_ready_low", in_ready32, 1'b0);
        check("bp_out_pc_first", out_pc32, 32'h100);
        in_valid = 1'b1;
        in_instr = 32'hFE000CE3;
        in_pc    = 64'h108;
        idle(2);
        check("bp_still_blocked", in_ready32, 1'b0);
        out_ready = 1'b1;
        push(32'hFE000CE3, 64'h108);
        push(32'h123450B7, 64'h10C);
        idle(4);
        check("bp_count", log_pc.size(), 4);
        if (log_pc.size() == 4) begin
            check("bp_order0", log_pc[0], 64'h100);
            check("bp_order1", log_pc[1], 64'h104);
            check("bp_order2", log_pc[2], 64'h108);
            check("bp_order3", log_pc[3], 64'h10C);
        end

        // Flush with skid full and a new instruction offered
        out_ready = 1'b0;
        push(32'h300FD073, 64'h200);
        push(32'h800000B7, 64'h204);
        check("fl_skid_full", in_ready32, 1'b0);
        log_pc.delete();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hFFDFF06F;
        in_pc    = 64'h208;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid32, 1'b0);
        check("fl_in_ready",  in_ready32,  1'b1);
        check("fl_out_valid64", out_valid64, 1'b0);
        out_ready = 1'b1;
        push(32'h30002073, 64'h20C);
        idle(3);
        check("fl_count", log_pc.size(), 1);
        if (log_pc.size() == 1) check("fl_survivor", log_pc[0], 64'h20C);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        push(32'hFFF00093, 64'h300);
        push(32'h123450B7, 64'h304);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid32, 1'b0);
        check("ar_out_imm",   out_imm32,   32'd0);
        check("ar_in_ready",  in_ready32,  1'b1);
        check("ar_out_imm64", out_imm64,   64'd0);
        check("ar_out_pc",    out_pc64,    64'd0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        push(32'h0010009B, 64'h400);
        check("ar_recover_imm64", out_imm64, 64'd1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
